// File: rtl/div.sv
// Restoring shift-subtract divider: 6-bit dividend / 3-bit divisor, one quotient
// bit per SHIFT+CHECK pair, MSB first, with a divide-by-zero short path.
module div (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic [5:0] dividend,
  input  logic [2:0] divisor,
  output logic [5:0] quotient,
  output logic [2:0] remainder,
  output logic       done,
  output logic       busy,
  output logic       dz
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_dvd;
  logic [2:0]  r_dvs;
  logic [3:0]  r_rem;
  logic [5:0]  r_quo;
  logic [2:0]  r_cnt;
  logic        w_ge;

  assign busy = (r_state != S_IDLE);
  assign w_ge = (r_rem >= {1'b0, r_dvs});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (init) w_next = S_LOAD;
      S_LOAD:   w_next = (r_dvs == 3'd0) ? S_FINISH : S_SHIFT;
      S_SHIFT:  w_next = S_CHECK;
      S_CHECK:  w_next = (r_cnt == 3'd0) ? S_FINISH : S_SHIFT;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Partial remainder is 4 bits: rem < divisor <= 7, so the shifted value is at most 15.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (init) begin
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= 3'd5;
          end
        end
        S_SHIFT: r_rem <= {r_rem[2:0], r_dvd[r_cnt]};
        S_CHECK: begin
          if (w_ge) begin
            r_rem <= r_rem - {1'b0, r_dvs};
            r_quo <= {r_quo[4:0], 1'b1};
          end else begin
            r_quo <= {r_quo[4:0], 1'b0};
          end
          if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        end
        S_FINISH: begin
          done <= 1'b1;
          if (r_dvs == 3'd0) begin
            quotient  <= '1;
            remainder <= '0;
            dz        <= 1'b1;
          end else begin
            quotient  <= r_quo;
            remainder <= r_rem[2:0];
            dz        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
